// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: decode-side request and read-data bundle for reg_file_mp.
// master = instruction decode / bench, slave = register file.
interface reg_file_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              clr_req;
    logic [1:0]        RegW;
    logic [ADDR_W-1:0] DR;
    logic [ADDR_W-1:0] SR1;
    logic [ADDR_W-1:0] SR2;
    logic [DATA_W-1:0] Write_data;
    logic [DATA_W-1:0] SR1_Data;
    logic [DATA_W-1:0] SR2_Data;
    logic              busy;

    modport master (
        output clr_req, RegW, DR, SR1, SR2, Write_data,
        input  SR1_Data, SR2_Data, busy
    );

    modport slave (
        input  clr_req, RegW, DR, SR1, SR2, Write_data,
        output SR1_Data, SR2_Data, busy
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: one-write / two-registered-read register file with a hardware
// clear sweep (every entry <- INIT_VAL after reset or on clr_req), read-hold
// mode (RegW=10) and optional write-first bypass.
// Optional feature macro: REG_FILE_MP_BYPASS_EN (undefined = read-first).
// The storage array has no reset so it can map onto RAM; the sweep initialises it.
module reg_file_mp #(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 4,
    parameter int              DEPTH    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = 16'd12345
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              busy_q;
    logic [DATA_W-1:0] sr1_q;
    logic [DATA_W-1:0] sr2_q;

    logic [DATA_W-1:0] sr1_d;
    logic [DATA_W-1:0] sr2_d;
    logic              run_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    function automatic logic in_range(input logic [ADDR_W-1:0] idx);
        return 32'(idx) < 32'(DEPTH);
    endfunction

    // Read-data selection and the single shared write port (sweep or RegW write).
    always_comb begin
        run_wr    = (state_q == RUN) && bus.RegW[0] && in_range(bus.DR);
        sr1_d     = '0;
        sr2_d     = '0;
        if (in_range(bus.SR1)) begin
            sr1_d = (BYPASS && run_wr && (bus.DR == bus.SR1)) ? bus.Write_data : mem[bus.SR1];
        end
        if (in_range(bus.SR2)) begin
            sr2_d = (BYPASS && run_wr && (bus.DR == bus.SR2)) ? bus.Write_data : mem[bus.SR2];
        end
        mem_we    = 1'b0;
        mem_waddr = bus.DR;
        mem_wdata = bus.Write_data;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = INIT_VAL;
        end else if (run_wr) begin
            mem_we    = 1'b1;
        end
    end

    // Storage array write, no reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Sweep/run sequencer with registered busy and read-data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            sr1_q     <= '0;
            sr2_q     <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    sr1_q <= '0;
                    sr2_q <= '0;
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q   <= RUN;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (bus.RegW != 2'b10) begin
                        sr1_q <= sr1_d;
                        sr2_q <= sr2_d;
                    end
                    if (bus.clr_req) begin
                        state_q   <= CLEAR;
                        clr_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

    assign bus.SR1_Data = sr1_q;
    assign bus.SR2_Data = sr2_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed plus randomized checks of reg_file_mp against a
// behavioural model (array + sweep countdown). Honours REG_FILE_MP_BYPASS_EN.
module tb_reg_file_mp;

    localparam int          DATA_W = 16;
    localparam int          ADDR_W = 4;
    localparam int          DEPTH  = 16;
    localparam logic [15:0] INIT   = 16'd12345;

`ifdef REG_FILE_MP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .INIT_VAL (INIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] mmem [DEPTH];
    int          sweep_left;
    logic [15:0] m_sr1;
    logic [15:0] m_sr2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        sweep_left = DEPTH;
        m_sr1 = '0;
        m_sr2 = '0;
    endtask

    function automatic logic [15:0] model_read(input int idx, input bit wr, input int widx, input logic [15:0] wd);
        if (idx >= DEPTH) return '0;
        if (BYPASS && wr && widx == idx) return wd;
        return mmem[idx];
    endfunction

    task automatic model_step();
        bit wr;
        if (sweep_left > 0) begin
            mmem[DEPTH - sweep_left] = INIT;
            sweep_left--;
            m_sr1 = '0;
            m_sr2 = '0;
        end else begin
            wr = bus.RegW[0] && (int'(bus.DR) < DEPTH);
            if (bus.RegW != 2'b10) begin
                m_sr1 = model_read(int'(bus.SR1), wr, int'(bus.DR), bus.Write_data);
                m_sr2 = model_read(int'(bus.SR2), wr, int'(bus.DR), bus.Write_data);
            end
            if (wr) mmem[bus.DR] = bus.Write_data;
            if (bus.clr_req) sweep_left = DEPTH;
        end
    endtask

    task automatic drive(input logic [1:0] regw, input int dr, input int s1, input int s2,
                         input logic [15:0] wd, input logic clr);
        bus.RegW       = regw;
        bus.DR         = ADDR_W'(dr);
        bus.SR1        = ADDR_W'(s1);
        bus.SR2        = ADDR_W'(s2);
        bus.Write_data = wd;
        bus.clr_req    = clr;
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("sr1", 32'(bus.SR1_Data), 32'(m_sr1));
        check_eq("sr2", 32'(bus.SR2_Data), 32'(m_sr2));
        check_eq("busy", 32'(bus.busy), 32'(sweep_left > 0));
    endtask

    // Counts clock edges spent with busy high, from the current negedge.
    task automatic count_sweep(input string tag);
        int cnt;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 64) begin
            cnt++;
            tick();
            if (bus.busy === 1'b1) check_eq({tag, "_out0"}, 32'(bus.SR1_Data), 32'h0);
        end
        check_eq({tag, "_edges"}, cnt, DEPTH);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        rst_n = 1'b0;
        drive(2'b10, 0, 0, 0, 16'h0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_sr1", 32'(bus.SR1_Data), 32'h0);
        check_eq("rst_sr2", 32'(bus.SR2_Data), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h1);

        // Release; writes attempted during the sweep must be dropped.
        drive(2'b11, 3, 3, 15, 16'hDEAD, 1'b0);
        rst_n = 1'b1;
        count_sweep("init");
        drive(2'b00, 0, 3, 15, 16'h0, 1'b0);
        tick();
        check_eq("init_r3", 32'(bus.SR1_Data), 32'(INIT));
        check_eq("init_r15", 32'(bus.SR2_Data), 32'(INIT));

        // Single write then read back.
        drive(2'b01, 5, 0, 0, 16'hBEEF, 1'b0);
        tick();
        drive(2'b00, 0, 5, 4, 16'h0, 1'b0);
        tick();
        check_eq("wr5", 32'(bus.SR1_Data), 32'hBEEF);
        check_eq("rd4", 32'(bus.SR2_Data), 32'(INIT));

        // Same-edge write/read of entry 7.
        drive(2'b11, 7, 7, 5, 16'h1234, 1'b0);
        tick();
        check_eq("byp7", 32'(bus.SR1_Data), BYPASS ? 32'h1234 : 32'(INIT));
        drive(2'b00, 0, 7, 5, 16'h0, 1'b0);
        tick();
        check_eq("after7", 32'(bus.SR1_Data), 32'h1234);

        // DISABLE holds outputs and blocks writes.
        drive(2'b00, 0, 5, 7, 16'h0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 5 + i, 9 + i, 1, 16'h0, 1'b0);
            tick();
            check_eq("hold", 32'(bus.SR1_Data), 32'hBEEF);
        end
        drive(2'b00, 0, 5, 6, 16'h0, 1'b0);
        tick();
        check_eq("hold_mem5", 32'(bus.SR1_Data), 32'hBEEF);
        check_eq("hold_mem6", 32'(bus.SR2_Data), 32'(INIT));

        // Async reset in RUN clears outputs between edges.
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_sr1", 32'(bus.SR1_Data), 32'h0);
        check_eq("arst_busy", 32'(bus.busy), 32'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        count_sweep("arst");
        drive(2'b01, 5, 0, 0, 16'hBEEF, 1'b0);
        tick();

        // clr_req with a same-edge write; clr_req during the sweep is ignored.
        drive(2'b01, 2, 5, 2, 16'h5555, 1'b1);
        tick();
        drive(2'b11, 2, 2, 5, 16'hAAAA, 1'b1);
        count_sweep("clr");
        drive(2'b00, 0, 2, 5, 16'h0, 1'b0);
        tick();
        check_eq("clr_r2", 32'(bus.SR1_Data), 32'(INIT));
        check_eq("clr_r5", 32'(bus.SR2_Data), 32'(INIT));

        // Reset mid-sweep at entry 9 restarts the sweep.
        drive(2'b10, 0, 0, 0, 16'h0, 1'b1);
        tick();
        drive(2'b10, 0, 0, 0, 16'h0, 1'b0);
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_sr1", 32'(bus.SR1_Data), 32'h0);
        check_eq("mid_sr2", 32'(bus.SR2_Data), 32'h0);
        check_eq("mid_busy", 32'(bus.busy), 32'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        count_sweep("mid");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(2'($urandom_range(0, 3)), $urandom_range(0, DEPTH - 1),
                  $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
                  16'($urandom), ($urandom_range(0, 39) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
